// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port among NREQ requesters and tracks pending writes; `RF_WB_RR_EN selects round-robin, otherwise fixed priority.
// Latency: handshake at edge N -> write presented in cycle N+1; ready never depends on the output stage (no self back-pressure).
module rf_wb_arbiter #(
   parameter int NREQ = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*5-1:0] req_reg,
   input  logic [NREQ*32-1:0] req_data,
   input  logic              reserve,
   input  logic [4:0]        reserve_reg,
   output logic [31:0]       busy,
   output logic              conflict,
   output logic              write,
   output logic [4:0]        write_reg,
   output logic [31:0]       write_data
);

   localparam int PW = $clog2(NREQ);

   typedef struct packed {
      logic [4:0]  wreg;
      logic [31:0] wdat;
   } wb_t;

   logic [PW-1:0]   gidx;
   logic [NREQ-1:0] grant;
   logic            hs;
   wb_t             win;

   logic            write_q, write_d;
   wb_t             out_q, out_d;
   logic [31:0]     busy_q, busy_d;
   logic            conflict_q, conflict_d;
   logic [31:0]     set_vec, clr_vec;

   function automatic logic [PW-1:0] lowest(input logic [NREQ-1:0] v);
      logic [PW-1:0] r;
      r = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (v[i]) r = PW'(i);
      end
      return r;
   endfunction

`ifdef RF_WB_RR_EN
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] above_ptr, masked;

   // Requesters above the last winner go first; wrap to the lowest valid otherwise.
   always_comb begin
      above_ptr = '0;
      for (int i = 0; i < NREQ; i++) begin
         above_ptr[i] = (PW'(i) > ptr_q);
      end
      masked = req_valid & above_ptr;
      gidx   = (|masked) ? lowest(masked) : lowest(req_valid);
   end

   assign ptr_d = hs ? gidx : ptr_q;

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= PW'(NREQ - 1);
      else     ptr_q <= ptr_d;
   end
`else
   always_comb gidx = lowest(req_valid);
`endif

   always_comb begin
      grant = '0;
      if (!rst && (|req_valid)) grant[gidx] = 1'b1;
   end

   assign req_ready = grant;
   assign hs        = |grant;

   always_comb begin
      win.wreg = req_reg[5*int'(gidx) +: 5];
      win.wdat = req_data[32*int'(gidx) +: 32];
   end

   // A write to r0 is consumed but never reaches the register file.
   always_comb begin
      write_d = 1'b0;
      out_d   = out_q;
      if (hs) begin
         write_d = (win.wreg != 5'd0);
         out_d   = win;
      end
   end

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (reserve && (reserve_reg != 5'd0)) set_vec[reserve_reg] = 1'b1;
      if (write_q) clr_vec[out_q.wreg] = 1'b1;
      busy_d     = (busy_q & ~clr_vec) | set_vec;
      busy_d[0]  = 1'b0;
      conflict_d = conflict_q | (|(set_vec & busy_q & ~clr_vec));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write_q    <= 1'b0;
         out_q      <= '0;
         busy_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         write_q    <= write_d;
         out_q      <= out_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   assign write      = write_q;
   assign write_reg  = out_q.wreg;
   assign write_data = out_q.wdat;
   assign busy       = busy_q;
   assign conflict   = conflict_q;

   a_one_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
   a_grant_valid: assert property (@(posedge clk) disable iff (rst) (req_ready & ~req_valid) == '0);
   a_no_starve_idle: assert property (@(posedge clk) disable iff (rst) (|req_valid) == (|req_ready));
   a_r0_free: assert property (@(posedge clk) disable iff (rst) !busy[0]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed plus randomized write-back traffic against a queue-based reference model.
// Driver pushes the expected post-edge output state; a monitor pops and compares after every edge.
module tb_rf_wb_arbiter;
   localparam int NREQ = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*5-1:0]    req_reg;
   logic [NREQ*32-1:0]   req_data;
   logic                 reserve;
   logic [4:0]           reserve_reg;
   logic [31:0]          busy;
   logic                 conflict;
   logic                 write;
   logic [4:0]           write_reg;
   logic [31:0]          write_data;

   rf_wb_arbiter #(.NREQ(NREQ)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_reg(req_reg), .req_data(req_data),
      .reserve(reserve), .reserve_reg(reserve_reg),
      .busy(busy), .conflict(conflict),
      .write(write), .write_reg(write_reg), .write_data(write_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        wr;
      bit [4:0]  wreg;
      bit [31:0] wdat;
      bit [31:0] busy;
      bit        conf;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   bit        pend_v[NREQ];
   bit [4:0]  pend_reg[NREQ];
   bit [31:0] pend_dat[NREQ];
   bit        rst_v;
   bit        res_en;
   bit [4:0]  res_reg;
   logic [NREQ-1:0] last_rdy;

   // reference model state: last presented output plus pending set and last winner
   bit        m_wr;
   bit [4:0]  m_wreg;
   bit [31:0] m_wdat;
   bit [31:0] m_busy;
   bit        m_conf;
   int        m_ptr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Round-robin: winner is the valid requester at the smallest cyclic distance after the last winner.
   function automatic int model_pick();
      int best  = -1;
      int bestd = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         if (pend_v[i]) begin
`ifdef RF_WB_RR_EN
            int d = (i - m_ptr - 1 + 2 * NREQ) % NREQ;
`else
            int d = i;
`endif
            if (d < bestd) begin
               bestd = d;
               best  = i;
            end
         end
      end
      return best;
   endfunction

   task automatic step();
      int   g;
      bit   confl;
      exp_t e;
      @(negedge clk);
      rst         = rst_v;
      reserve     = res_en;
      reserve_reg = res_reg;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]        = pend_v[i];
         req_reg[5*i +: 5]   = pend_reg[i];
         req_data[32*i +: 32] = pend_dat[i];
      end
      #1;
      g = rst_v ? -1 : model_pick();
      last_rdy = req_ready;
      chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      e = '{default: 0};
      if (rst_v) begin
         m_ptr = NREQ - 1;
      end else begin
         e.busy = m_busy;
         if (m_wr) e.busy[m_wreg] = 1'b0;
         confl = 1'b0;
         if (res_en && res_reg != 5'd0) begin
            confl = m_busy[res_reg] && !(m_wr && m_wreg == res_reg);
            e.busy[res_reg] = 1'b1;
         end
         e.conf = m_conf || confl;
         if (g >= 0) begin
            e.wr   = (pend_reg[g] != 5'd0);
            e.wreg = pend_reg[g];
            e.wdat = pend_dat[g];
            m_ptr  = g;
         end else begin
            e.wr   = 1'b0;
            e.wreg = m_wreg;
            e.wdat = m_wdat;
         end
      end
      m_wr = e.wr; m_wreg = e.wreg; m_wdat = e.wdat; m_busy = e.busy; m_conf = e.conf;
      exp_q.push_back(e);
      @(posedge clk);
      if (g >= 0) pend_v[g] = 1'b0;
   endtask

   function automatic bit any_pend();
      bit r = 1'b0;
      for (int i = 0; i < NREQ; i++) r |= pend_v[i];
      return r;
   endfunction

   task automatic drain();
      for (int k = 0; k < 4 * NREQ && any_pend(); k++) step();
      chk("drain_done", 32'(any_pend()), 32'd0);
   endtask

   task automatic set_req(input int i, input bit [4:0] r, input bit [31:0] d);
      pend_v[i] = 1'b1; pend_reg[i] = r; pend_dat[i] = d;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("write", 32'(write), 32'(e.wr));
            chk("write_reg", 32'(write_reg), 32'(e.wreg));
            chk("write_data", write_data, e.wdat);
            chk("busy", busy, e.busy);
            chk("conflict", 32'(conflict), 32'(e.conf));
         end
      end
   end

   initial begin : driver
      logic [NREQ-1:0] gseq[4];
      logic [4:0]      wseq[4];
      logic [NREQ-1:0] exp_g[4];
      logic [4:0]      exp_w[4];

      rst = 1'b1; req_valid = '0; req_reg = '0; req_data = '0; reserve = 1'b0; reserve_reg = '0;
      for (int i = 0; i < NREQ; i++) begin pend_v[i] = 0; pend_reg[i] = 0; pend_dat[i] = 0; end
      res_en = 0; res_reg = 0; m_ptr = NREQ - 1;
      m_wr = 0; m_wreg = 0; m_wdat = 0; m_busy = 0; m_conf = 0;

      rst_v = 1'b1; step(); step(); rst_v = 1'b0;

      // single write to r5
      res_en = 1; res_reg = 5'd5; step(); res_en = 0;
      set_req(1, 5'd5, 32'hDEADBEEF); step();
      chk("single_ready", 32'(last_rdy), 32'b010);
      #2;
      chk("single_write", 32'(write), 32'd1);
      chk("single_reg", 32'(write_reg), 32'd5);
      chk("single_data", write_data, 32'hDEADBEEF);
      chk("single_busy5_held", 32'(busy[5]), 32'd1);
      step(); #2;
      chk("single_busy5_clr", 32'(busy[5]), 32'd0);

      // all three held valid with regs 1/2/3
      rst_v = 1; step(); rst_v = 0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + i);
         step();
         gseq[c] = last_rdy;
         #2;
         wseq[c] = write_reg;
      end
`ifdef RF_WB_RR_EN
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
      exp_w = '{5'd1, 5'd2, 5'd3, 5'd1};
`else
      exp_g = '{3'b001, 3'b001, 3'b001, 3'b001};
      exp_w = '{5'd1, 5'd1, 5'd1, 5'd1};
`endif
      for (int c = 0; c < 4; c++) begin
         chk("arb_grant_seq", 32'(gseq[c]), 32'(exp_g[c]));
         chk("arb_wreg_seq", 32'(wseq[c]), 32'(exp_w[c]));
      end
      drain();

      // register 0
      set_req(2, 5'd0, 32'h1234); step();
      chk("r0_ready", 32'(last_rdy), 32'b100);
      #2;
      chk("r0_write", 32'(write), 32'd0);
      chk("r0_busy", busy, 32'd0);
      res_en = 1; res_reg = 5'd0; step(); res_en = 0; #2;
      chk("r0_reserve", busy, 32'd0);

      // set/clear collision on r7
      res_en = 1; res_reg = 5'd7; step(); res_en = 0;
      set_req(0, 5'd7, 32'h77); step(); #2;
      chk("coll_write", 32'(write), 32'd1);
      chk("coll_wreg", 32'(write_reg), 32'd7);
      res_en = 1; res_reg = 5'd7; step(); res_en = 0; #2;
      chk("coll_busy7", 32'(busy[7]), 32'd1);
      chk("coll_noconf", 32'(conflict), 32'd0);
      res_en = 1; res_reg = 5'd7; step(); res_en = 0; #2;
      chk("coll_conf", 32'(conflict), 32'd1);

      // reset while busy=0x90 and a write is presented
      res_en = 1; res_reg = 5'd4; step(); res_en = 0;
      set_req(1, 5'd4, 32'h44); step(); #2;
      chk("mid_busy", busy, 32'h0000_0090);
      chk("mid_write", 32'(write), 32'd1);
      for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 10), 32'hB000_0000 + i);
      rst_v = 1; step(); rst_v = 0;
      chk("mid_rst_ready", 32'(last_rdy), 32'd0);
      #2;
      chk("mid_rst_busy", busy, 32'd0);
      chk("mid_rst_write", 32'(write), 32'd0);
      chk("mid_rst_conf", 32'(conflict), 32'd0);
      step();
      chk("post_rst_grant", 32'(last_rdy), 32'b001);
      drain();

      // randomized traffic
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend_v[i] && $urandom_range(0, 9) < 5)
               set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
         end
         res_en  = ($urandom_range(0, 2) == 0);
         res_reg = 5'($urandom_range(0, 31));
         rst_v   = ($urandom_range(0, 99) == 0);
         step();
      end
      rst_v = 0; res_en = 0;
      drain();
      step(); step();
      repeat (2) @(posedge clk);
      #2;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 register file. It shares the register file's single write port between NREQ write-back requesters, such as the ALU pipe, load unit and mul/div unit. Each requester uses a valid/ready handshake. The block also tracks destination registers with pending writes, so issue logic can stall on RAW hazards. It sits between the execution units and the register file's `write`/`write_reg`/`write_data` inputs.

## Interface
- `NREQ`, default 3: number of write-back requesters (2..8).
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: requester i holds a write-back.
- `req_ready` output NREQ: grant to requester i this cycle; the handshake completes when `req_valid[i] && req_ready[i]`.
- `req_reg` input NREQ*5: destination of requester i, in bits [5i+4:5i].
- `req_data` input NREQ*32: data of requester i, in bits [32i+31:32i].
- `reserve` input 1: issue logic reserves a destination this cycle.
- `reserve_reg` input 5: register being reserved.
- `busy` output 32: bit r set means register r has a pending write. Bit 0 is always 0.
- `conflict` output 1: sticky flag; a busy register was reserved again.
- `write` output 1: write enable to the register file.
- `write_reg` output 5: register-file write address.
- `write_data` output 32: register-file write data.

## Operation
- **Arbitration**
  - `req_ready` is combinational from `req_valid` and the priority pointer `ptr`.
  - At most one bit of `req_ready` is set per cycle, and only for a requester with valid=1.
  - A grant is never withheld while any requester is valid. Throughput is one write-back per cycle.
- **Round-robin order**
  - The search order starts at `(ptr+1) mod NREQ`.
  - On a handshake by requester g, `ptr` becomes g. With no handshake, `ptr` holds.
- **Output stage**
  - A handshake loads `write_reg`/`write_data` from the winner on the next edge.
  - `write` is set to 1 if the winner's `req_reg` is nonzero. If `req_reg` = 0, `write` is set to 0: the write is consumed and dropped.
  - With no handshake, `write` is 0 and `write_reg`/`write_data` hold their values.
- **Scoreboard**
  - Set: `reserve && reserve_reg != 0` sets `busy[reserve_reg]` on the edge.
  - Clear: a registered output `write=1` clears `busy[write_reg]` on the edge after it is presented, i.e. the edge on which the register file captures it.
  - Same register set and cleared in one cycle: set wins.
  - Reserving register 0 is ignored.
  - Reserving a register that is already busy, with no clear of it that cycle, leaves it busy and sets `conflict`.
  - `conflict` clears only on reset.
- **Reset**
  - `rst` clears `ptr` to NREQ-1, so requester 0 has first priority.
  - It also clears `busy`, `conflict`, `write`, `write_reg` and `write_data`.
  - `req_ready` is forced to 0 while `rst` is 1.
  - An in-flight output write is dropped; the register file must be reset alongside.

## Timing
- Handshake at edge N → `write`/`write_reg`/`write_data` valid during cycle N+1 → register file captures and `busy` clears at edge N+2.
- Requesters must hold `req_valid`, `req_reg` and `req_data` stable until the handshake completes. `req_valid` must not drop before ready.
- `busy` is a registered output. A reservation made at edge N is visible from cycle N+1.
- `req_ready` has no dependency on the output stage; the block never back-pressures itself.

## Configuration
- `RF_WB_RR_EN` defined: round-robin arbitration using `ptr`, as described above.
- `RF_WB_RR_EN` undefined:
  - Fixed priority; the lowest index wins.
  - `ptr` is not implemented.
  - Starvation of higher indices is permitted and must be avoided by the system.

## Test plan
- **Single write:** after reset, reserve r5, then `req_valid[1]`=1, reg 5, data 0xDEADBEEF.
  - `req_ready[1]`=1 in the same cycle.
  - Next cycle: `write`=1, `write_reg`=5, `write_data`=0xDEADBEEF.
  - `busy[5]` is 1 until the following edge, then 0.
- **Round robin (RF_WB_RR_EN):** all three requesters held valid with regs 1/2/3.
  - Grants follow 0,1,2,0,… with one per cycle.
  - `write_reg` sequence is 1,2,3,1.
- **Fixed priority (no macro):** same stimulus as the round-robin test.
  - Requester 0 is granted every cycle.
  - Requesters 1 and 2 never get ready while requester 0 stays valid.
- **Register 0:** request to reg 0 with data 0x1234.
  - Handshake completes.
  - `write` stays 0 and `busy` stays 0.
  - Reserve of r0 leaves `busy[0]`=0.
- **Set/clear collision:** r7 write presented (`write`=1, `write_reg`=7) while `reserve` targets r7.
  - `busy[7]` stays 1 and `conflict` stays 0.
  - A repeat reserve of r7 with no write sets `conflict`=1.
- **Reset mid-operation:** assert `rst` for one cycle while `busy`=0x00000090 and `write`=1.
  - Next cycle: `busy`=0, `write`=0, `conflict`=0, `req_ready`=0.
  - The first post-reset grant goes to requester 0.
